// File: rtl/hyperbus_dly_pkg.sv
// Shared types for the HyperBus delay-line controller: FSM states, request
// modes and the calibration window record.
package hyperbus_dly_pkg;

  // Window fields are sized for the widest supported tap code.
  localparam int DLY_TAP_W_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } dly_state_e;

  typedef enum logic {
    DLY_MODE_DIRECT = 1'b0,
    DLY_MODE_SWEEP  = 1'b1
  } dly_mode_e;

  typedef struct packed {
    logic                     found;
    logic [DLY_TAP_W_MAX-1:0] lo;
    logic [DLY_TAP_W_MAX-1:0] hi;
  } dly_win_t;

  // Midpoint of lo..hi with one extra bit so lo+hi cannot wrap.
  function automatic logic [DLY_TAP_W_MAX-1:0] dly_centre(
    input logic [DLY_TAP_W_MAX-1:0] lo,
    input logic [DLY_TAP_W_MAX-1:0] hi
  );
    logic [DLY_TAP_W_MAX:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[DLY_TAP_W_MAX:1];
  endfunction

endpackage

// File: rtl/hyperbus_dly_stepper.sv
// One delay-line tap register that walks toward its target by a single tap
// per enabled update-window cycle, so the delay path never sees a jump.
module hyperbus_dly_stepper #(
  parameter int TAP_W     = 3,
  parameter int RESET_TAP = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             upd_win_i,
  input  logic [TAP_W-1:0] target_i,
  output logic [TAP_W-1:0] tap_o,
  output logic             at_target_o
);

  assign at_target_o = (tap_o == target_i);

  // Moving strictly toward an in-range target can never wrap the code.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap_o <= TAP_W'(RESET_TAP);
    end else if (en_i && upd_win_i && !at_target_o) begin
      if (tap_o < target_i) tap_o <= tap_o + 1'b1;
      else                  tap_o <= tap_o - 1'b1;
    end
  end

endmodule

// File: rtl/hyperbus_delay_line_ctrl.sv
// Per-channel delay-line tap controller: glitch-safe direct tap moves and a
// calibration sweep that parks the tap at the centre of the first pass window.
//
// state  | meaning
// IDLE   | ready for a request
// STEP   | walking the selected channel's tap toward target_q
// SETTLE | letting the delay path settle after a tap change
// SAMPLE | waiting for the sampler verdict on the current tap
// DONE   | one-cycle completion pulse
module hyperbus_delay_line_ctrl
  import hyperbus_dly_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int TAP_W         = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESET_TAP     = 0
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       cfg_valid_i,
  output logic                                       cfg_ready_o,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_chan_i,
  input  logic                                       cfg_mode_i,
  input  logic [TAP_W-1:0]                           cfg_tap_i,
  input  logic                                       upd_win_i,
  output logic                                       sample_req_o,
  input  logic                                       sample_valid_i,
  input  logic                                       sample_pass_i,
  output logic [NUM_CH*TAP_W-1:0]                    tap_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       found_o,
  output logic [TAP_W-1:0]                           win_lo_o,
  output logic [TAP_W-1:0]                           win_hi_o
);

  localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CH_W:0]     NUM_CH_X = (CH_W + 1)'(NUM_CH);
  localparam logic [TAP_W-1:0]  TAP_MAX  = '1;

  dly_state_e        state_q;
  dly_mode_e         mode_q;
  logic [CH_W-1:0]   chan_q;
  logic              final_q;
  logic [TAP_W-1:0]  target_q;
  logic [TAP_W-1:0]  orig_q;
  logic [CNT_W-1:0]  settle_cnt_q;
  dly_win_t          rec_q;
  logic              open_q;

  logic [TAP_W-1:0]  taps [NUM_CH];
  logic [NUM_CH-1:0] at_tgt;
  logic [TAP_W-1:0]  cur_tap;
  logic              cur_at;
  logic [TAP_W-1:0]  in_tap;
  logic              chan_ok;
  logic              step_en;

  dly_win_t                 rec_nxt;
  logic                     open_nxt;
  logic [DLY_TAP_W_MAX-1:0] cur_tap_x;
  logic [DLY_TAP_W_MAX-1:0] centre_w;
  logic                     unused_win;

  assign cfg_ready_o = (state_q == ST_IDLE);
  assign busy_o      = !cfg_ready_o;
  assign chan_ok     = ({1'b0, cfg_chan_i} < NUM_CH_X);
  assign step_en     = (state_q == ST_STEP);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hyperbus_dly_stepper #(
      .TAP_W     (TAP_W),
      .RESET_TAP (RESET_TAP)
    ) u_stepper (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (step_en && (chan_q == CH_W'(c))),
      .upd_win_i   (upd_win_i),
      .target_i    (target_q),
      .tap_o       (taps[c]),
      .at_target_o (at_tgt[c])
    );
    assign tap_o[c*TAP_W +: TAP_W] = taps[c];
  end

  always_comb begin
    cur_tap = '0;
    cur_at  = 1'b0;
    in_tap  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan_q == CH_W'(c)) begin
        cur_tap = taps[c];
        cur_at  = at_tgt[c];
      end
      if (cfg_chan_i == CH_W'(c)) in_tap = taps[c];
    end
  end

  // Only the first contiguous run of passes is recorded; open_q drops on the
  // first fail after it, after which later passes are ignored.
  always_comb begin
    rec_nxt   = rec_q;
    open_nxt  = open_q;
    cur_tap_x = DLY_TAP_W_MAX'(cur_tap);
    if (sample_pass_i) begin
      if (!rec_q.found) begin
        rec_nxt.found = 1'b1;
        rec_nxt.lo    = cur_tap_x;
        rec_nxt.hi    = cur_tap_x;
        open_nxt      = 1'b1;
      end else if (open_q) begin
        rec_nxt.hi = cur_tap_x;
      end
    end else begin
      open_nxt = 1'b0;
    end
    centre_w = dly_centre(rec_nxt.lo, rec_nxt.hi);
  end

  assign unused_win = ^{rec_q.lo, rec_q.hi, centre_w};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= DLY_MODE_DIRECT;
      chan_q       <= '0;
      final_q      <= 1'b0;
      target_q     <= TAP_W'(RESET_TAP);
      orig_q       <= TAP_W'(RESET_TAP);
      settle_cnt_q <= '0;
      rec_q        <= '0;
      open_q       <= 1'b0;
      done_o       <= 1'b0;
      sample_req_o <= 1'b0;
      found_o      <= 1'b0;
      win_lo_o     <= '0;
      win_hi_o     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            chan_q  <= cfg_chan_i;
            mode_q  <= dly_mode_e'(cfg_mode_i);
            final_q <= 1'b0;
            if (!chan_ok) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
            end else if (dly_mode_e'(cfg_mode_i) == DLY_MODE_SWEEP) begin
              orig_q   <= in_tap;
              target_q <= '0;
              rec_q    <= '0;
              open_q   <= 1'b0;
              state_q  <= ST_STEP;
            end else begin
              target_q <= cfg_tap_i;
              state_q  <= ST_STEP;
            end
          end
        end

        ST_STEP: begin
          if (cur_at) begin
            if (mode_q == DLY_MODE_DIRECT || final_q) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
            end else begin
              settle_cnt_q <= CNT_W'(SETTLE_CYCLES);
              state_q      <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == CNT_W'(1)) begin
            state_q      <= ST_SAMPLE;
            sample_req_o <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (sample_valid_i) begin
            sample_req_o <= 1'b0;
            rec_q        <= rec_nxt;
            open_q       <= open_nxt;
            state_q      <= ST_STEP;
            if (cur_tap != TAP_MAX) begin
              target_q <= cur_tap + 1'b1;
            end else begin
              final_q <= 1'b1;
              if (rec_nxt.found) begin
                target_q <= centre_w[TAP_W-1:0];
                found_o  <= 1'b1;
                win_lo_o <= rec_nxt.lo[TAP_W-1:0];
                win_hi_o <= rec_nxt.hi[TAP_W-1:0];
              end else begin
                target_q <= orig_q;
                found_o  <= 1'b0;
                win_lo_o <= '0;
                win_hi_o <= '0;
              end
            end
          end
        end

        ST_DONE: begin
          done_o  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_delay_line_ctrl.sv
// Scoreboard bench for hyperbus_delay_line_ctrl: a tap/window reference model
// predicts each request's outcome, a monitor checks it at every done_o pulse.
module tb_hyperbus_delay_line_ctrl;

  localparam int NUM_CH = 3;
  localparam int TAP_W  = 3;
  localparam int SETTLE = 4;
  localparam int NT     = 1 << TAP_W;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    cfg_valid_i = 1'b0;
  logic                    cfg_ready_o;
  logic [CH_W-1:0]         cfg_chan_i = '0;
  logic                    cfg_mode_i = 1'b0;
  logic [TAP_W-1:0]        cfg_tap_i = '0;
  logic                    upd_win_i = 1'b1;
  logic                    sample_req_o;
  logic                    sample_valid_i = 1'b0;
  logic                    sample_pass_i = 1'b0;
  logic [NUM_CH*TAP_W-1:0] tap_o;
  logic                    busy_o, done_o, found_o;
  logic [TAP_W-1:0]        win_lo_o, win_hi_o;

  hyperbus_delay_line_ctrl #(
    .NUM_CH(NUM_CH), .TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE), .RESET_TAP(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_chan_i(cfg_chan_i), .cfg_mode_i(cfg_mode_i), .cfg_tap_i(cfg_tap_i),
    .upd_win_i(upd_win_i), .sample_req_o(sample_req_o), .sample_valid_i(sample_valid_i),
    .sample_pass_i(sample_pass_i), .tap_o(tap_o), .busy_o(busy_o), .done_o(done_o),
    .found_o(found_o), .win_lo_o(win_lo_o), .win_hi_o(win_hi_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH*TAP_W-1:0] taps;
    int found, lo, hi, nreq, lat;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0, n_fail = 0;
  int            cyc = 0, acc_cyc = 0, req_cnt = 0;
  int            m_tap[NUM_CH];
  int            m_found = 0, m_lo = 0, m_hi = 0;
  logic [NT-1:0] pass_mask = '0;
  int            upd_mode = 0, act_chan = 0, samp_dly = 0;
  bit            skip_step = 1'b1, upd_seen = 1'b0, last_req = 1'b0;
  logic [NUM_CH*TAP_W-1:0] last_taps = '0;
  int            since_chg = 100;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    upd_seen = upd_win_i;
  end

  always @(negedge clk) begin
    case (upd_mode)
      0:       upd_win_i = 1'b1;
      1:       upd_win_i = !upd_win_i;
      default: upd_win_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Sampler: answers each request after 0..2 cycles with the mask verdict for
  // the tap it sees, and now and then raises a stray result when not asked.
  always @(negedge clk) begin
    logic [TAP_W-1:0] t;
    if (rst_i) begin
      sample_valid_i = 1'b0;
    end else if (sample_req_o && !sample_valid_i) begin
      if (samp_dly == 0) begin
        t = tap_o[act_chan*TAP_W +: TAP_W];
        sample_valid_i = 1'b1;
        sample_pass_i  = pass_mask[t];
        samp_dly = $urandom_range(0, 2);
      end else begin
        samp_dly--;
      end
    end else if (!sample_req_o && $urandom_range(0, 7) == 0) begin
      sample_valid_i = 1'b1;
      sample_pass_i  = 1'($urandom_range(0, 1));
    end else begin
      sample_valid_i = 1'b0;
    end
  end

  // Tap-motion monitor: every change is a single step on the active channel
  // in a window cycle; each sample request must follow a settle interval.
  always @(negedge clk) begin
    int cur, prv;
    bit chg;
    if (skip_step) begin
      last_taps = tap_o;
      last_req  = sample_req_o;
      since_chg = 100;
    end else begin
      chg = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cur = int'(tap_o[c*TAP_W +: TAP_W]);
        prv = int'(last_taps[c*TAP_W +: TAP_W]);
        if (cur != prv) begin
          chg = 1'b1;
          n_cmp++;
          if (!(c == act_chan && upd_seen && (cur - prv == 1 || prv - cur == 1))) begin
            n_fail++;
            $display("FAIL tap_move ch%0d: %0d -> %0d upd=%0d active=%0d", c, prv, cur, upd_seen, act_chan);
          end
        end
      end
      last_taps = tap_o;
      since_chg = chg ? 0 : since_chg + 1;
      if (sample_req_o && !last_req) begin
        req_cnt++;
        n_cmp++;
        if (since_chg < SETTLE) begin
          n_fail++;
          $display("FAIL settle: sample_req %0d cycles after tap change, need >= %0d", since_chg, SETTLE);
        end
      end
      last_req = sample_req_o;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("taps", int'(tap_o), int'(e.taps));
        chk("found", int'(found_o), e.found);
        chk("win_lo", int'(win_lo_o), e.lo);
        chk("win_hi", int'(win_hi_o), e.hi);
        chk("sample_req_count", req_cnt, e.nreq);
        if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
      end
    end
  end

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_tap[c] = 0;
    m_found = 0; m_lo = 0; m_hi = 0;
  endtask

  task automatic issue(input int ch, input int md, input int tp,
                       input logic [NT-1:0] mask, input int um, input bit wait_done);
    exp_t e;
    int   lo, hi, d;
    bit   ok;
    pass_mask = mask;
    upd_mode  = um;
    act_chan  = ch;
    e.lat  = -1;
    e.nreq = 0;
    if (ch >= NUM_CH) begin
      e.lat = 1;
    end else if (md == 0) begin
      d = (tp > m_tap[ch]) ? tp - m_tap[ch] : m_tap[ch] - tp;
      if (um == 0) e.lat = d + 2;
      m_tap[ch] = tp;
    end else begin
      e.nreq = NT;
      lo = -1;
      for (int t = NT - 1; t >= 0; t--) if (mask[t]) lo = t;
      if (lo >= 0) begin
        hi = lo;
        while (hi < NT - 1 && mask[hi+1]) hi++;
        m_found = 1; m_lo = lo; m_hi = hi;
        m_tap[ch] = (lo + hi) / 2;
      end else begin
        m_found = 0; m_lo = 0; m_hi = 0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) e.taps[c*TAP_W +: TAP_W] = TAP_W'(m_tap[c]);
    e.found = m_found; e.lo = m_lo; e.hi = m_hi;
    exp_q.push_back(e);

    @(negedge clk);
    cfg_valid_i = 1'b1;
    cfg_chan_i  = CH_W'(ch);
    cfg_mode_i  = 1'(md);
    cfg_tap_i   = TAP_W'(tp);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (cfg_ready_o) begin
        acc_cyc = cyc;
        req_cnt = 0;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!wait_done) return;

    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      // Requests raised while busy must be ignored.
      cfg_valid_i = !cfg_ready_o && ($urandom_range(0, 3) == 0);
      cfg_chan_i  = CH_W'($urandom_range(0, 3));
      cfg_mode_i  = 1'($urandom_range(0, 1));
      cfg_tap_i   = TAP_W'($urandom_range(0, NT - 1));
      if (exp_q.size() == 0) ok = 1'b1;
    end
    cfg_valid_i = 1'b0;
    if (!ok) begin
      chk("done_timeout", 0, 1);
      skip_step = 1'b1;
      rst_i = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      model_reset();
      @(negedge clk);
      skip_step = 1'b0;
    end
  endtask

  initial begin
    int            ch, md, tp, um, a, b;
    logic [NT-1:0] mk;
    model_reset();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_taps", int'(tap_o), 0);
    chk("rst_ready", int'(cfg_ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_sample_req", int'(sample_req_o), 0);
    chk("rst_found", int'(found_o), 0);
    chk("rst_win_lo", int'(win_lo_o), 0);
    chk("rst_win_hi", int'(win_hi_o), 0);
    skip_step = 1'b0;

    issue(0, 0, 5, 8'h00, 0, 1);
    issue(1, 0, 6, 8'h00, 1, 1);
    issue(0, 1, 0, 8'b0011_1100, 0, 1);
    issue(0, 0, 4, 8'h00, 0, 1);
    issue(0, 1, 0, 8'b0000_0000, 2, 1);
    issue(0, 1, 0, 8'b0100_0010, 0, 1);
    issue(1, 1, 0, 8'b1100_0000, 1, 1);
    issue(NUM_CH, 0, 3, 8'h00, 0, 1);
    issue(NUM_CH, 1, 0, 8'hFF, 2, 1);

    for (int k = 0; k < 40; k++) begin
      ch = $urandom_range(0, NUM_CH);
      md = $urandom_range(0, 1);
      tp = $urandom_range(0, NT - 1);
      um = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        mk = NT'($urandom);
      end else begin
        a  = $urandom_range(0, NT - 1);
        b  = $urandom_range(a, NT - 1);
        mk = '0;
        for (int i = a; i <= b; i++) mk[i] = 1'b1;
      end
      issue(ch, md, tp, mk, um, 1);
    end

    // Abort a sweep while it is settling.
    issue(0, 0, 0, 8'h00, 0, 1);
    issue(2, 0, 7, 8'h00, 0, 1);
    issue(0, 1, 0, 8'b0001_1000, 0, 0);
    @(negedge clk);
    cfg_valid_i = 1'b0;
    @(negedge clk);
    skip_step = 1'b1;
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_taps", int'(tap_o), 0);
    chk("abort_ready", int'(cfg_ready_o), 1);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_sample_req", int'(sample_req_o), 0);
    rst_i = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done_o), 0);
    end
    chk("abort_found", int'(found_o), 0);
    skip_step = 1'b0;
    issue(1, 0, 2, 8'h00, 0, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperbus_delay_line_ctrl.md
Name: hyperbus_delay_line_ctrl

Overview:
- Parametrised controller for NUM_CH programmable delay lines, each selected by a TAP_W-bit tap code.
- Owns the per-channel tap registers and moves them glitch-safely: one tap step per cycle, and only inside an externally signalled update window.
- Adds a calibration sweep mode. Per channel, it scans all 2**TAP_W taps, records the first contiguous pass window from an external sampler, and parks the tap at the window centre.
- Sits between the uDMA HyperBus config registers and the per-channel delay lines of the RWDS/clock paths.

Parameters:
- NUM_CH, 2, number of delay-line channels (>=1).
- TAP_W, 3, tap code width; 2**TAP_W taps.
- SETTLE_CYCLES, 4, cycles to wait after a tap change before sampling (>=1).
- RESET_TAP, 0, tap loaded into every channel at reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- cfg_valid_i  in  1  request valid.
- cfg_ready_o  out  1  controller idle, accepts request.
- cfg_chan_i  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_mode_i  in  1  0 = direct set, 1 = sweep calibration.
- cfg_tap_i  in  TAP_W  target tap (direct mode only).
- upd_win_i  in  1  tap may change this cycle (delay path quiet).
- sample_req_o  out  1  sweep: sampler should evaluate the current tap.
- sample_valid_i  in  1  sampler result valid.
- sample_pass_i  in  1  sampler result: 1 = pass.
- tap_o  out  NUM_CH*TAP_W  per-channel tap codes; channel c at [c*TAP_W +: TAP_W].
- busy_o  out  1  request in progress.
- done_o  out  1  one-cycle pulse at request completion.
- found_o  out  1  last sweep found a pass window (held until next sweep).
- win_lo_o, win_hi_o  out  TAP_W  last sweep window bounds (held).

Behaviour:
- Reset: tap_o = RESET_TAP on all channels; cfg_ready_o = 1; busy_o, done_o, sample_req_o, found_o = 0; win_lo_o = win_hi_o = 0; FSM in IDLE.
- Handshake: a request is accepted on cfg_valid_i && cfg_ready_o. Channel, mode and tap are captured at acceptance. cfg_ready_o = (state == IDLE). busy_o = !cfg_ready_o.
- States: IDLE, STEP, SETTLE, SAMPLE, DONE.
- Stepping rule (STEP): in any cycle with upd_win_i = 1 and cur != target, cur moves by +1 or -1 toward target. No other change to tap_o is permitted. With upd_win_i = 0, tap_o holds.
- Direct mode:
  - IDLE -> STEP on acceptance.
  - STEP -> DONE once cur == target; this also applies when target already equals cur at acceptance.
  - DONE lasts 1 cycle: done_o = 1, then IDLE.
  - Latency with upd_win_i held high = |target - cur| + 2 cycles from acceptance to done_o.
- Sweep mode:
  - Save the original tap. Target = 0. IDLE -> STEP.
  - STEP reached target -> SETTLE.
  - SETTLE counts SETTLE_CYCLES, then -> SAMPLE.
  - SAMPLE drives sample_req_o = 1 until sample_valid_i; the result is consumed in that same cycle.
  - Window record: the first pass sets lo = hi = tap; each subsequent pass that immediately follows a pass sets hi = tap; any pass after the window has closed (a fail following a pass) is ignored.
  - If tap < 2**TAP_W-1: target = tap+1 -> STEP. Otherwise go to centre computation.
  - Centre: centre = (lo + hi) >> 1, computed in TAP_W+1 bits, no wrap. Target = centre, found_o = 1, win_lo_o/win_hi_o updated.
  - No pass found: target = original tap, found_o = 0, win_lo_o/win_hi_o = 0.
  - Then STEP -> DONE (done_o pulse).
- Tap arithmetic saturates; the tap never wraps from 2**TAP_W-1 to 0.
- Boundary conditions:
  - cfg_chan_i >= NUM_CH: request accepted, no tap change, done_o pulses 1 cycle later, found_o unchanged.
  - sample_valid_i outside SAMPLE is ignored.
  - cfg_valid_i while busy is not accepted; it must be held.
  - Untouched channels never change.
  - rst_i mid-operation aborts immediately to reset values; no done_o is emitted.

Decomposition:
- Package hyperbus_dly_pkg: FSM state enum, mode encoding (DLY_MODE_DIRECT = 0, DLY_MODE_SWEEP = 1), and a window-record struct {found, lo, hi}.
- Sub-module hyperbus_dly_stepper: one tap register with target compare, ±1 step gated by upd_win_i, and an at_target flag. Instantiated once per channel; only the selected channel's enable is asserted.

Test Plan:
- Reset, then direct chan0 tap=5 with upd_win_i=1 -> tap_o[2:0] steps 0,1,2,3,4,5 on consecutive cycles; done_o 7 cycles after acceptance; chan1 stays 0.
- Direct chan1 tap=6 with upd_win_i toggling 1,0,1,0... -> tap changes only in window cycles; no step larger than 1; final tap 6.
- Sweep chan0, pass on taps 2..5 only -> found_o=1, win_lo_o=2, win_hi_o=5, final tap 3; sample_req_o asserted 8 times; each assertion at least SETTLE_CYCLES after a tap change.
- Sweep chan0 from tap 4, all fail -> found_o=0, final tap returns to 4; pass on taps 1 and 6 only -> window 1..1, final tap 1.
- Sweep with pass on taps 6..7 (top edge) -> centre 6 with no overflow. Then cfg_chan_i=NUM_CH -> done_o 1 cycle later, all taps unchanged.
- Assert rst_i during SETTLE of a sweep -> all taps = RESET_TAP, cfg_ready_o = 1, no done_o.
